// File: rtl/mc_pkg.sv
// Shared types, encodings and the condition-code check for the multicycle controller.
package mc_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_ORR = 2'b11
   } alu_ctrl_t;

   typedef enum logic [1:0] {
      RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10
   } result_src_t;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   // nzcv is {N,Z,C,V}; code 1111 falls to the default and never executes
   function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v;
      {n, z, c, v} = nzcv;
      case (cond)
         COND_EQ: return z;
         COND_NE: return ~z;
         COND_CS: return c;
         COND_CC: return ~c;
         COND_MI: return n;
         COND_PL: return ~n;
         COND_VS: return v;
         COND_VC: return ~v;
         COND_HI: return c & ~z;
         COND_LS: return ~(c & ~z);
         COND_GE: return n == v;
         COND_LT: return n != v;
         COND_GT: return ~z & (n == v);
         COND_LE: return ~(~z & (n == v));
         COND_AL: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mc_condunit.sv
// Architectural NZCV flag register and the combinational condition check.
module mc_condunit
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex
);

   logic [3:0] flags_q, flags_d;

   // flag_w[1] updates N,Z; flag_w[0] updates C,V
   always_comb begin
      cond_ex = cond_check(cond, flags_q);
      flags_d = flags_q;
      if (flag_w[1] && cond_ex) flags_d[3:2] = alu_flags[3:2];
      if (flag_w[0] && cond_ex) flags_d[1:0] = alu_flags[1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) flags_q <= 4'b0000;
      else       flags_q <= flags_d;
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle sequencer: main FSM, ALU decoder and output decode for the ARMv4-subset datapath.
module mc_controller
   import mc_pkg::*;
#(
   parameter int unsigned MEM_HS = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] instr,
   input  logic [3:0]  alu_flags,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_write,
   output logic [1:0]  result_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  imm_src,
   output logic [1:0]  reg_src,
   output logic [1:0]  alu_ctrl
);

   logic [3:0]  cond, cmd, rd;
   logic [1:0]  op;
   logic        i_bit, s_bit, l_bit;
   logic        mem_ok, cond_ex, dp_known;
   logic [1:0]  flag_w;
   logic        unused_rn;
   state_t      state_q, state_d;
   alu_ctrl_t   dp_ctrl, ctrl_sel;
   result_src_t res_sel;

   assign cond      = instr[19:16];
   assign op        = instr[15:14];
   assign i_bit     = instr[13];
   assign cmd       = instr[12:9];
   assign s_bit     = instr[8];
   assign l_bit     = instr[8];
   assign rd        = instr[3:0];
   assign unused_rn = ^instr[7:4];

   assign mem_ok = (MEM_HS == 0) || mem_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (mem_ok) state_d = DECODE;
         DECODE: begin
            case (op)
               OP_MEM:  state_d = MEMADR;
               OP_DP:   state_d = i_bit ? EXECI : EXECR;
               OP_BR:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = l_bit ? MEMRD : MEMWR;
         MEMRD:   if (mem_ok) state_d = MEMWB;
         MEMWB:   state_d = FETCH;
         MEMWR:   if (mem_ok) state_d = FETCH;
         EXECR:   state_d = ALUWB;
         EXECI:   state_d = ALUWB;
         ALUWB:   state_d = FETCH;
         BRANCH:  state_d = FETCH;
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Unimplemented commands fall back to ADD and never touch the flags
   always_comb begin
      dp_ctrl  = ALU_ADD;
      dp_known = 1'b1;
      case (cmd)
         CMD_ADD: dp_ctrl = ALU_ADD;
         CMD_SUB: dp_ctrl = ALU_SUB;
         CMD_AND: dp_ctrl = ALU_AND;
         CMD_ORR: dp_ctrl = ALU_ORR;
         default: dp_known = 1'b0;
      endcase
   end

   always_comb begin
      flag_w = 2'b00;
      if (state_q == EXECR || state_q == EXECI) begin
         flag_w[1] = s_bit & dp_known;
         flag_w[0] = s_bit & dp_known & (cmd == CMD_ADD || cmd == CMD_SUB);
      end
   end

   mc_condunit u_condunit (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond),
      .alu_flags (alu_flags),
      .flag_w    (flag_w),
      .cond_ex   (cond_ex)
   );

   always_comb begin
      pc_write  = 1'b0;
      adr_src   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      res_sel   = RES_ALURESULT;
      alu_src_a = 1'b1;
      alu_src_b = 2'b10;
      ctrl_sel  = ALU_ADD;
      case (state_q)
         FETCH: begin
            ir_write = mem_ok;
            pc_write = mem_ok;
         end
         MEMADR: begin
            alu_src_a = 1'b0;
            alu_src_b = 2'b01;
         end
         MEMRD:   adr_src = 1'b1;
         MEMWB: begin
            res_sel   = RES_DATA;
            reg_write = cond_ex;
         end
         MEMWR: begin
            adr_src   = 1'b1;
            mem_write = cond_ex;
         end
         EXECR, EXECI: begin
            alu_src_a = 1'b0;
            alu_src_b = (state_q == EXECI) ? 2'b01 : 2'b00;
            ctrl_sel  = dp_ctrl;
         end
         ALUWB: begin
            res_sel   = RES_ALUOUT;
            reg_write = cond_ex;
            pc_write  = cond_ex && (rd == 4'd15);
         end
         BRANCH: begin
            alu_src_a = 1'b0;
            alu_src_b = 2'b01;
            pc_write  = cond_ex;
         end
         default: ;
      endcase
      // Reset kills any in-flight strobe immediately, not at the next edge
      if (reset) begin
         pc_write  = 1'b0;
         mem_write = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign result_src = res_sel;
   assign alu_ctrl   = ctrl_sel;
   assign imm_src    = (op == OP_BR) ? 2'b10 : ((op == OP_MEM) ? 2'b01 : 2'b00);
   assign reg_src    = {op == OP_MEM, op == OP_BR};

endmodule
